ntt_stage_sched: RTL and testbench

Sequencer for a single pipelined radix-2 butterfly unit in the NTT core. It walks all log2(N) stages of an in-place Gentleman-Sande (DIF) NTT. For each butterfly it issues an address pair and a twiddle index. It counts butterflies in flight in the pipeline and waits for the pipeline to drain between stages, so that stage s+1 never reads a location before stage s has written it back. The butterfly's write-back valid comes from the valid-delay chain alongside the datapath and is returned here as wb_valid.

---
 rtl/ntt_stage_sched.sv | 156 +++++++++++++++
 tb/tb_ntt_stage_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// Butterfly issue sequencer for an in-place DIF NTT.
// Walks every stage, drains the pipeline between stages.
module ntt_stage_sched #(
    parameter int N = 256,
    localparam int AW = $clog2(N),
    localparam int SW = ($clog2(AW) < 1) ? 1 : $clog2(AW),
    localparam int CW = $clog2(N / 2 + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          issue_ready,
    input  logic          wb_valid,
    output logic          issue_valid,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-2:0] tw_idx,
    output logic [SW-1:0] stage,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(AW - 1);
    localparam logic [AW-2:0] LAST_K = '1;

    state_t        state;
    logic [AW-2:0] k;
    logic [CW-1:0] outstanding;
    logic          xfer;
    logic [SW-1:0] ld_s;
    logic [AW-2:0] ld_k;

    // Butterfly span h = N >> (s+1)
    function automatic logic [AW-1:0] span(input logic [SW-1:0] s);
        return AW'(N / 2) >> s;
    endfunction

    // g*2h + j: low bits of k stay, high bits move up by one
    function automatic logic [AW-1:0] upper(input logic [SW-1:0] s,
                                            input logic [AW-2:0] kk);
        logic [AW-1:0] m;
        logic [AW-1:0] kx;
        m  = span(s) - AW'(1);
        kx = {1'b0, kk};
        return ((kx & ~m) << 1) | (kx & m);
    endfunction

    function automatic logic [AW-2:0] twiddle(input logic [SW-1:0] s,
                                              input logic [AW-2:0] kk);
        logic [AW-1:0] m;
        logic [AW-1:0] j;
        m = span(s) - AW'(1);
        j = {1'b0, kk} & m;
        return (AW-1)'(j << s);
    endfunction

    assign xfer = issue_valid & issue_ready;

    // Stage/index of the butterfly loaded on the next update
    always_comb begin
        ld_s = stage;
        ld_k = k + 1'b1;
        if (state == IDLE) begin
            ld_s = '0;
            ld_k = '0;
        end else if (state == DRAIN) begin
            ld_s = stage + 1'b1;
            ld_k = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            outstanding <= '0;
            issue_valid <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            tw_idx      <= '0;
            stage       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;

            if (xfer && !wb_valid) begin
                outstanding <= outstanding + 1'b1;
            end else if (wb_valid && !xfer && outstanding != '0) begin
                outstanding <= outstanding - 1'b1;
            end
            if (wb_valid && outstanding == '0) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ISSUE;
                        stage       <= ld_s;
                        k           <= ld_k;
                        issue_valid <= 1'b1;
                        addr_a      <= upper(ld_s, ld_k);
                        addr_b      <= upper(ld_s, ld_k) | span(ld_s);
                        tw_idx      <= twiddle(ld_s, ld_k);
                        busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (k == LAST_K) begin
                            state       <= DRAIN;
                            issue_valid <= 1'b0;
                        end else begin
                            k      <= ld_k;
                            addr_a <= upper(ld_s, ld_k);
                            addr_b <= upper(ld_s, ld_k) | span(ld_s);
                            tw_idx <= twiddle(ld_s, ld_k);
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        if (stage < LAST_STAGE) begin
                            state       <= ISSUE;
                            stage       <= ld_s;
                            k           <= ld_k;
                            issue_valid <= 1'b1;
                            addr_a      <= upper(ld_s, ld_k);
                            addr_b      <= upper(ld_s, ld_k) | span(ld_s);
                            tw_idx      <= twiddle(ld_s, ld_k);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched at N=8 with a delayed write-back
// pipeline model and an arithmetic reference of the DIF schedule.
module tb_ntt_stage_sched;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int SW = 2;
    localparam int NX = (N / 2) * AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          issue_ready;
    logic          wb_valid;
    logic          issue_valid;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-2:0] tw_idx;
    logic [SW-1:0] stage;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    ntt_stage_sched #(.N(N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid),
        .issue_valid(issue_valid),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .tw_idx(tw_idx),
        .stage(stage),
        .busy(busy),
        .done(done),
        .err(err)
    );

    typedef struct {
        int s;
        int a;
        int b;
        int tw;
    } bf_t;

    bf_t vec[NX];
    bf_t log_q[$];
    int  due[$];

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int delay = 3;
    bit rand_ready = 1'b0;
    int xfers;
    int wb_seen;
    int done_cnt;
    bit prev_hold;
    int pa, pb, ptw;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                      name, act, exp, $time);
    endtask

    // One clock cycle of pipeline model; entered and left at a negedge
    task automatic step();
        bf_t e;
        if (prev_hold) begin
            chk("hold_valid", int'(issue_valid), 1);
            chk("hold_a", int'(addr_a), pa);
            chk("hold_b", int'(addr_b), pb);
            chk("hold_tw", int'(tw_idx), ptw);
        end
        issue_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (issue_valid && issue_ready) begin
            if (log_q.size() > 0 && int'(stage) != log_q[$].s)
                chk("drained_before_next_stage", wb_seen, xfers);
            e.s  = int'(stage);
            e.a  = int'(addr_a);
            e.b  = int'(addr_b);
            e.tw = int'(tw_idx);
            log_q.push_back(e);
            xfers++;
            due.push_back(cyc + delay);
        end
        wb_valid = 1'b0;
        if (due.size() > 0 && due[0] == cyc) begin
            void'(due.pop_front());
            wb_valid = 1'b1;
            wb_seen++;
        end
        prev_hold = issue_valid && !issue_ready;
        pa  = int'(addr_a);
        pb  = int'(addr_b);
        ptw = int'(tw_idx);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (done) begin
            done_cnt++;
            chk("busy_with_done", int'(busy), 1);
        end
    endtask

    task automatic clear_run(input int d, input bit rr);
        delay = d;
        rand_ready = rr;
        log_q.delete();
        due.delete();
        xfers = 0;
        wb_seen = 0;
        done_cnt = 0;
        prev_hold = 1'b0;
    endtask

    task automatic run(input int d, input bit rr, input bit restart,
                       input int exp_err, input bit use_table);
        int n;
        bit pulsed;
        int s, k, h, a;
        clear_run(d, rr);
        pulsed = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            if (restart && !pulsed && stage == 1 && busy) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            step();
            start = 1'b0;
            n++;
        end
        chk("finished_in_budget", int'(done_cnt != 0), 1);
        repeat (4) step();
        chk("done_once", done_cnt, 1);
        chk("idle_after_done", int'(busy), 0);
        chk("final_stage", int'(stage), AW - 1);
        chk("err_flag", int'(err), exp_err);
        chk("transfer_count", xfers, NX);
        chk("wb_count", wb_seen, xfers);
        if (restart) chk("restart_was_pulsed", int'(pulsed), 1);
        for (int i = 0; i < log_q.size() && i < NX; i++) begin
            s = i / (N / 2);
            k = i % (N / 2);
            h = N >> (s + 1);
            a = (k / h) * 2 * h + (k % h);
            chk("seq_stage", log_q[i].s, s);
            chk("seq_a", log_q[i].a, a);
            chk("seq_b", log_q[i].b, a + h);
            chk("seq_tw", log_q[i].tw, (k % h) << s);
            if (use_table) begin
                chk("tab_a", log_q[i].a, vec[i].a);
                chk("tab_b", log_q[i].b, vec[i].b);
                chk("tab_tw", log_q[i].tw, vec[i].tw);
            end
        end
    endtask

    initial begin
        int n;
        vec = '{
            '{0, 0, 4, 0}, '{0, 1, 5, 1}, '{0, 2, 6, 2}, '{0, 3, 7, 3},
            '{1, 0, 2, 0}, '{1, 1, 3, 2}, '{1, 4, 6, 0}, '{1, 5, 7, 2},
            '{2, 0, 1, 0}, '{2, 2, 3, 0}, '{2, 4, 5, 0}, '{2, 6, 7, 0}
        };
        reset = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        wb_valid = 1'b0;
        clear_run(3, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(issue_valid), 0);
        chk("rst_a", int'(addr_a), 0);
        chk("rst_b", int'(addr_b), 0);
        chk("rst_tw", int'(tw_idx), 0);
        chk("rst_stage", int'(stage), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);

        run(3, 1'b0, 1'b0, 0, 1'b1);
        run(10, 1'b0, 1'b0, 0, 1'b0);
        run(3, 1'b1, 1'b0, 0, 1'b1);
        run(3, 1'b0, 1'b1, 0, 1'b0);
        run(3, 1'b0, 1'b0, 0, 1'b1);

        // Abort while draining stage 1
        clear_run(10, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(stage == 1 && busy && !issue_valid) && n < 500) begin
            step();
            n++;
        end
        chk("reached_stage1_drain", int'(n < 500), 1);
        reset = 1'b1;
        #1;
        chk("abort_valid", int'(issue_valid), 0);
        chk("abort_a", int'(addr_a), 0);
        chk("abort_b", int'(addr_b), 0);
        chk("abort_tw", int'(tw_idx), 0);
        chk("abort_stage", int'(stage), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        due.delete();
        wb_valid = 1'b0;
        prev_hold = 1'b0;
        done_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) step();
        chk("no_done_after_abort", done_cnt, 0);
        chk("idle_after_abort", int'(busy), 0);
        run(3, 1'b0, 1'b0, 0, 1'b1);

        // Stray write-back while idle
        wb_valid = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("err_set", int'(err), 1);
        clear_run(3, 1'b0);
        repeat (3) step();
        chk("err_sticky", int'(err), 1);
        run(3, 1'b0, 1'b0, 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
